// File: rtl/cnn_window_gen.sv
// cnn_window_gen
//   Producer side of the convolver window interface. Takes a raster-order
//   32-bit pixel stream, keeps the previous KERNEL_SIZE-1 rows in line
//   buffers, and emits one kh x kw window per legal stride-1, no-padding
//   output position. The output register honours window_stall back-pressure.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   conf_refresh_i        latch config and start (or restart) a frame
//   kernel_height_i/
//   kernel_width_i        one-hot kernel edges (highest set bit wins, 0 -> 1)
//   img_width_i/
//   img_height_i          frame size in pixels (width clamped to MAX_IMG_WIDTH)
//   stride2_i             only with CNN_WINDOW_STRIDE2_EN: emit every other
//                         window in both directions
//   pixel_valid_i/pixel_i/
//   pixel_ready_o         input pixel handshake
//   window_valid_o/
//   window_o              window bus, lane i = row r, col c with i = r*kw + c
//   window_stall_i        consumer frozen, hold outputs
//   frame_done_o          one-cycle pulse once the last window has left
//
// Optional feature macro: CNN_WINDOW_STRIDE2_EN
//
// state | meaning
// IDLE  | waiting for conf_refresh, no pixels accepted
// RUN   | accepting pixels, producing windows
// DONE  | all pixels taken, waiting for the last window to drain

module cnn_window_gen #(
  parameter int WINDOW_SIZE   = 9,
  parameter int KERNEL_SIZE   = 3,
  parameter int MAX_IMG_WIDTH = 32,
  parameter int IMG_DIM_W     = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        conf_refresh_i,
  input  logic [KERNEL_SIZE-1:0]      kernel_height_i,
  input  logic [KERNEL_SIZE-1:0]      kernel_width_i,
  input  logic [IMG_DIM_W-1:0]        img_width_i,
  input  logic [IMG_DIM_W-1:0]        img_height_i,
`ifdef CNN_WINDOW_STRIDE2_EN
  input  logic                        stride2_i,
`endif
  input  logic                        pixel_valid_i,
  input  logic [31:0]                 pixel_i,
  output logic                        pixel_ready_o,
  output logic                        window_valid_o,
  output logic [WINDOW_SIZE*32-1:0]   window_o,
  input  logic                        window_stall_i,
  output logic                        frame_done_o
);

  localparam int KD_W    = $clog2(KERNEL_SIZE + 1);
  localparam int LB_ROWS = KERNEL_SIZE - 1;
  localparam int XA_W    = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [IMG_DIM_W-1:0]       x_q, x_d, y_q, y_d;
  logic [IMG_DIM_W-1:0]       w_q, w_d, h_q, h_d;
  logic [KD_W-1:0]            kh_q, kh_d, kw_q, kw_d;
  logic                       win_valid_q, win_valid_d;
  logic [WINDOW_SIZE*32-1:0]  win_q, win_d;
  logic                       frame_done_q, frame_done_d;

  // lb_q[LB_ROWS-1] holds the most recent completed row, lb_q[0] the oldest.
  logic [31:0] lb_q [LB_ROWS][MAX_IMG_WIDTH];
  // Column shift register: col_q[c][r], c = KERNEL_SIZE-1 is the newest column.
  logic [31:0] col_q [KERNEL_SIZE][KERNEL_SIZE];
  logic [31:0] sr_n  [KERNEL_SIZE][KERNEL_SIZE];

  logic                       accept;
  logic [XA_W-1:0]            xa;
  logic [IMG_DIM_W-1:0]       kh_m1, kw_m1;
  logic                       last_x, last_y, win_pos, stride_ok;
  logic [WINDOW_SIZE*32-1:0]  win_new;
  logic [IMG_DIM_W-1:0]       w_cfg;
  int                         khi, kwi;

  function automatic logic [KD_W-1:0] decode_edge(input logic [KERNEL_SIZE-1:0] oh);
    logic [KD_W-1:0] e;
    e = KD_W'(1);
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      if (oh[k]) e = KD_W'(k + 1);
    end
    return e;
  endfunction

  // A refresh cycle never accepts a pixel: that pixel would belong to the
  // frame being thrown away.
  assign pixel_ready_o = (state_q == S_RUN) && !window_stall_i && !conf_refresh_i;
  assign accept        = pixel_valid_i && pixel_ready_o;

  assign xa     = x_q[XA_W-1:0];
  assign kh_m1  = IMG_DIM_W'(kh_q) - IMG_DIM_W'(1);
  assign kw_m1  = IMG_DIM_W'(kw_q) - IMG_DIM_W'(1);
  assign last_x = (x_q == w_q - IMG_DIM_W'(1));
  assign last_y = (y_q == h_q - IMG_DIM_W'(1));
  assign w_cfg  = (img_width_i > IMG_DIM_W'(MAX_IMG_WIDTH)) ? IMG_DIM_W'(MAX_IMG_WIDTH)
                                                             : img_width_i;

`ifdef CNN_WINDOW_STRIDE2_EN
  logic s2_q, s2_d;
  // Offsets from the first legal position are even iff the low bits match.
  assign stride_ok = !s2_q || ((y_q[0] == kh_m1[0]) && (x_q[0] == kw_m1[0]));
`else
  assign stride_ok = 1'b1;
`endif

  assign win_pos = (y_q >= kh_m1) && (x_q >= kw_m1) && stride_ok;

  // Window contents as they will be after this pixel is shifted in.
  always_comb begin
    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        sr_n[c][r] = col_q[c+1][r];
      end
    end
    for (int r = 0; r < LB_ROWS; r++) begin
      sr_n[KERNEL_SIZE-1][r] = lb_q[r][xa];
    end
    sr_n[KERNEL_SIZE-1][KERNEL_SIZE-1] = pixel_i;
  end

  // The active kh x kw window is the bottom-right corner of the full
  // KERNEL_SIZE square; pack it densely from lane 0.
  always_comb begin
    win_new = '0;
    khi     = int'(kh_q);
    kwi     = int'(kw_q);
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        if (r >= KERNEL_SIZE - khi && c >= KERNEL_SIZE - kwi) begin
          win_new[((r - (KERNEL_SIZE - khi)) * kwi + (c - (KERNEL_SIZE - kwi))) * 32 +: 32]
            = sr_n[c][r];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    kh_d         = kh_q;
    kw_d         = kw_q;
    win_valid_d  = win_valid_q;
    win_d        = win_q;
    frame_done_d = 1'b0;
`ifdef CNN_WINDOW_STRIDE2_EN
    s2_d         = s2_q;
`endif

    if (!window_stall_i) begin
      win_valid_d = 1'b0;
      win_d       = '0;
    end

    case (state_q)
      S_RUN: begin
        if (accept) begin
          if (win_pos) begin
            win_valid_d = 1'b1;
            win_d       = win_new;
          end
          if (last_x) begin
            x_d = '0;
            y_d = y_q + IMG_DIM_W'(1);
            if (last_y) state_d = S_DONE;
          end else begin
            x_d = x_q + IMG_DIM_W'(1);
          end
        end
      end
      S_DONE: begin
        // An unstalled cycle here hands the final window to the consumer.
        if (!window_stall_i) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (conf_refresh_i) begin
      state_d      = S_RUN;
      x_d          = '0;
      y_d          = '0;
      w_d          = w_cfg;
      h_d          = img_height_i;
      kh_d         = decode_edge(kernel_height_i);
      kw_d         = decode_edge(kernel_width_i);
      win_valid_d  = 1'b0;
      win_d        = '0;
      frame_done_d = 1'b0;
`ifdef CNN_WINDOW_STRIDE2_EN
      s2_d         = stride2_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= IMG_DIM_W'(1);
      h_q          <= IMG_DIM_W'(1);
      kh_q         <= KD_W'(1);
      kw_q         <= KD_W'(1);
      win_valid_q  <= 1'b0;
      win_q        <= '0;
      frame_done_q <= 1'b0;
`ifdef CNN_WINDOW_STRIDE2_EN
      s2_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      kh_q         <= kh_d;
      kw_q         <= kw_d;
      win_valid_q  <= win_valid_d;
      win_q        <= win_d;
      frame_done_q <= frame_done_d;
`ifdef CNN_WINDOW_STRIDE2_EN
      s2_q         <= s2_d;
`endif
    end
  end

  // Pixel storage needs no reset: a window only reads rows and columns
  // written earlier in the same frame.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int r = 0; r < LB_ROWS - 1; r++) begin
        lb_q[r][xa] <= lb_q[r+1][xa];
      end
      lb_q[LB_ROWS-1][xa] <= pixel_i;
      col_q <= sr_n;
    end
  end

  assign window_valid_o = win_valid_q;
  assign window_o       = win_q;
  assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen. Pixels carry their raster index
// (y*W + x), so every expected window lane is computable from its position.

module tb_cnn_window_gen;
  localparam int WS = 9;
  localparam int K  = 3;
  localparam int DW = 6;
  localparam int VW = WS * 32;
  typedef logic [VW-1:0] vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            conf_refresh;
  logic [K-1:0]    kernel_height, kernel_width;
  logic [DW-1:0]   img_width, img_height;
  logic            stride2;
  logic            pixel_valid;
  logic [31:0]     pixel;
  logic            pixel_ready;
  logic            window_valid;
  vec_t            window;
  logic            window_stall;
  logic            frame_done;

  always #5 clk = ~clk;

  cnn_window_gen #(
    .WINDOW_SIZE(WS), .KERNEL_SIZE(K), .MAX_IMG_WIDTH(32), .IMG_DIM_W(DW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .conf_refresh_i(conf_refresh),
    .kernel_height_i(kernel_height),
    .kernel_width_i(kernel_width),
    .img_width_i(img_width),
    .img_height_i(img_height),
`ifdef CNN_WINDOW_STRIDE2_EN
    .stride2_i(stride2),
`endif
    .pixel_valid_i(pixel_valid),
    .pixel_i(pixel),
    .pixel_ready_o(pixel_ready),
    .window_valid_o(window_valid),
    .window_o(window),
    .window_stall_i(window_stall),
    .frame_done_o(frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  int   m_w, m_h, m_kh, m_kw, m_s2, m_x, m_y;
  int   feed_idx, feed_lim;
  bit   feeding;
  vec_t exp_q[$];
  logic [31:0] br_q[$];
  int   win_cnt, done_cnt, acc_cnt, cyc;
  int   first_valid_cyc, acc10_cyc;
  vec_t first_win, last_win, hold;
  int   hv[9];

  task automatic chk(input string tag, input vec_t obs, input vec_t expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic vec_t exp_window(input int y, input int x);
    vec_t v;
    v = '0;
    for (int r = 0; r < m_kh; r++)
      for (int c = 0; c < m_kw; c++)
        v[(r*m_kw + c)*32 +: 32] = 32'((y - m_kh + 1 + r) * m_w + (x - m_kw + 1 + c));
    return v;
  endfunction

  function automatic vec_t pack9(input int v[9]);
    vec_t p;
    p = '0;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = 32'(v[i]);
    return p;
  endfunction

  // One clock: observe at the falling edge, then return 1 time unit after
  // the rising edge so the caller can drive the next inputs.
  task automatic tick();
    bit   acc;
    vec_t e;
    @(negedge clk);
    if (window_valid && !window_stall) begin
      win_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      br_q.push_back(window[VW-1 -: 32]);
      if (exp_q.size() == 0) begin
        chk("spurious_window", vec_t'(window_valid), vec_t'(0));
      end else begin
        e = exp_q.pop_front();
        chk("window", window, e);
        if (win_cnt == 1) first_win = window;
        last_win = window;
      end
    end
    if (frame_done) begin
      done_cnt++;
      chk("done_with_valid", vec_t'(window_valid), vec_t'(0));
      chk("done_before_last_window", vec_t'(exp_q.size()), vec_t'(0));
    end
    acc = pixel_valid && pixel_ready;
    if (acc) begin
      acc_cnt++;
      if (pixel == 32'd10) acc10_cyc = cyc;
      if (m_y >= m_kh - 1 && m_x >= m_kw - 1 &&
          (m_s2 == 0 || (((m_y - m_kh + 1) % 2) == 0 && ((m_x - m_kw + 1) % 2) == 0)))
        exp_q.push_back(exp_window(m_y, m_x));
      if (m_x == m_w - 1) begin
        m_x = 0;
        m_y++;
      end else begin
        m_x++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc && feeding) begin
      feed_idx++;
      if (feed_idx >= feed_lim) begin
        pixel_valid = 1'b0;
        feeding     = 1'b0;
      end else begin
        pixel = 32'(feed_idx);
      end
    end
  endtask

  task automatic configure(input logic [K-1:0] oh_h, input logic [K-1:0] oh_w,
                           input int kh, input int kw, input int w, input int h,
                           input int s2);
    kernel_height = oh_h;
    kernel_width  = oh_w;
    img_width     = DW'(w);
    img_height    = DW'(h);
    stride2       = s2[0];
    conf_refresh  = 1'b1;
    tick();
    conf_refresh  = 1'b0;
    chk("valid_after_refresh", vec_t'(window_valid), vec_t'(0));
    m_kh = kh; m_kw = kw; m_w = w; m_h = h; m_s2 = s2;
    m_x = 0; m_y = 0;
    exp_q.delete();
    br_q.delete();
    win_cnt = 0; done_cnt = 0; acc_cnt = 0;
    first_valid_cyc = -1; acc10_cyc = -100;
  endtask

  task automatic start_feed(input int lim);
    feed_idx    = 0;
    feed_lim    = lim;
    pixel       = 32'd0;
    pixel_valid = 1'b1;
    feeding     = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    repeat (3) tick();
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !window_valid; i++) tick();
    chk(tag, vec_t'(window_valid), vec_t'(1));
  endtask

  initial begin
    rst = 1'b1; conf_refresh = 1'b0; kernel_height = '0; kernel_width = '0;
    img_width = '0; img_height = '0; stride2 = 1'b0; pixel_valid = 1'b0;
    pixel = '0; window_stall = 1'b0; feeding = 1'b0; cyc = 0;
    m_w = 1; m_h = 1; m_kh = 1; m_kw = 1; m_s2 = 0; m_x = 0; m_y = 0;
    win_cnt = 0; done_cnt = 0; acc_cnt = 0; first_valid_cyc = -1; acc10_cyc = -100;

    // Reset state
    repeat (2) tick();
    pixel_valid = 1'b1;
    #1;
    chk("rst_pixel_ready", vec_t'(pixel_ready), vec_t'(0));
    chk("rst_window_valid", vec_t'(window_valid), vec_t'(0));
    chk("rst_window", window, vec_t'(0));
    chk("rst_frame_done", vec_t'(frame_done), vec_t'(0));
    pixel_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_ready_after_rst", vec_t'(pixel_ready), vec_t'(0));

    // 4x4 image, 3x3 kernel
    configure(3'b100, 3'b100, 3, 3, 4, 4, 0);
    start_feed(16);
    wait_done(200);
    chk("t1_windows", vec_t'(win_cnt), vec_t'(4));
    chk("t1_done_pulses", vec_t'(done_cnt), vec_t'(1));
    chk("t1_pixels", vec_t'(acc_cnt), vec_t'(16));
    hv = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    chk("t1_first_window", first_win, pack9(hv));
    hv = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    chk("t1_last_window", last_win, pack9(hv));
    chk("t1_latency", vec_t'(first_valid_cyc - acc10_cyc), vec_t'(1));
    chk("t1_idle_ready", vec_t'(pixel_ready), vec_t'(0));

    // 3x3 image, 2x2 kernel
    configure(3'b010, 3'b010, 2, 2, 3, 3, 0);
    start_feed(9);
    wait_done(200);
    chk("t2_windows", vec_t'(win_cnt), vec_t'(4));
    chk("t2_done_pulses", vec_t'(done_cnt), vec_t'(1));
    hv = '{0, 1, 3, 4, 0, 0, 0, 0, 0};
    chk("t2_first_window", first_win, pack9(hv));

    // Stall held for 3 cycles on the first window
    configure(3'b100, 3'b100, 3, 3, 4, 4, 0);
    start_feed(16);
    wait_valid("t3_window_appeared");
    hold = window;
    window_stall = 1'b1;
    #1;
    chk("t3_ready_stalled", vec_t'(pixel_ready), vec_t'(0));
    repeat (3) begin
      tick();
      chk("t3_window_held", window, hold);
      chk("t3_valid_held", vec_t'(window_valid), vec_t'(1));
      chk("t3_ready_held", vec_t'(pixel_ready), vec_t'(0));
    end
    window_stall = 1'b0;
    wait_done(200);
    chk("t3_windows", vec_t'(win_cnt), vec_t'(4));
    chk("t3_done_pulses", vec_t'(done_cnt), vec_t'(1));

    // 5 wide, 2 high with a 3x3 kernel: no windows
    configure(3'b100, 3'b100, 3, 3, 5, 2, 0);
    start_feed(10);
    wait_done(200);
    chk("t4_windows", vec_t'(win_cnt), vec_t'(0));
    chk("t4_pixels", vec_t'(acc_cnt), vec_t'(10));
    chk("t4_done_pulses", vec_t'(done_cnt), vec_t'(1));

    // Abort after 7 pixels, then a fresh frame
    configure(3'b100, 3'b100, 3, 3, 4, 4, 0);
    start_feed(7);
    for (int i = 0; i < 60 && feeding; i++) tick();
    chk("t5_pixels_before_abort", vec_t'(acc_cnt), vec_t'(7));
    configure(3'b100, 3'b100, 3, 3, 4, 4, 0);
    start_feed(16);
    wait_done(200);
    chk("t5_windows", vec_t'(win_cnt), vec_t'(4));
    chk("t5_done_pulses", vec_t'(done_cnt), vec_t'(1));

    // Abort while a window is held under stall
    configure(3'b100, 3'b100, 3, 3, 4, 4, 0);
    start_feed(16);
    wait_valid("t6_window_appeared");
    window_stall = 1'b1;
    feeding = 1'b0;
    pixel_valid = 1'b0;
    tick();
    configure(3'b100, 3'b100, 3, 3, 4, 4, 0);
    window_stall = 1'b0;
    start_feed(16);
    wait_done(200);
    chk("t6_windows", vec_t'(win_cnt), vec_t'(4));
    chk("t6_done_pulses", vec_t'(done_cnt), vec_t'(1));

    // Reset mid-frame with a window on the bus
    configure(3'b100, 3'b100, 3, 3, 4, 4, 0);
    start_feed(16);
    wait_valid("t7_window_appeared");
    rst = 1'b1;
    feeding = 1'b0;
    pixel_valid = 1'b0;
    tick();
    chk("t7_rst_valid", vec_t'(window_valid), vec_t'(0));
    chk("t7_rst_window", window, vec_t'(0));
    chk("t7_rst_done", vec_t'(frame_done), vec_t'(0));
    pixel_valid = 1'b1;
    #1;
    chk("t7_rst_ready", vec_t'(pixel_ready), vec_t'(0));
    pixel_valid = 1'b0;
    rst = 1'b0;
    tick();

`ifdef CNN_WINDOW_STRIDE2_EN
    // Stride 2 on a 5x5 image with a 3x3 kernel
    configure(3'b100, 3'b100, 3, 3, 5, 5, 1);
    start_feed(25);
    wait_done(200);
    chk("t8_windows", vec_t'(win_cnt), vec_t'(4));
    chk("t8_done_pulses", vec_t'(done_cnt), vec_t'(1));
    if (br_q.size() == 4) begin
      chk("t8_br0", vec_t'(br_q[0]), vec_t'(12));
      chk("t8_br1", vec_t'(br_q[1]), vec_t'(14));
      chk("t8_br2", vec_t'(br_q[2]), vec_t'(22));
      chk("t8_br3", vec_t'(br_q[3]), vec_t'(24));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
